// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the CPU memory bus.
// Holds the responder state encoding and the default bus width, address width,
// wait-state count and read-only boundary. The control-side bus logic imports
// the same package so both ends agree on these values.
package mem_pkg;

  localparam int MEM_WIDTH_MAIN  = 8;
  localparam int MEM_WIDTH_AX    = 16;
  localparam int MEM_WAIT_STATES = 2;
  localparam int MEM_WAIT_CNT_W  = 4;
  localparam logic [15:0] MEM_ROM_TOP = 16'h8000;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_ACK  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with write enable and read enable.
// Ports:
//   clk   - clock, all updates on the rising edge
//   reset - synchronous active-high; clears only the read data register
//   we    - write wdata to addr on this edge
//   re    - capture ram[addr] into rdata on this edge
//   addr  - shared read/write address
//   wdata - write data
//   rdata - registered read data, holds until the next enabled read
module mem_array #(
  parameter int WIDTH_DATA = 8,
  parameter int WIDTH_ADDR = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [WIDTH_ADDR-1:0] addr,
  input  logic [WIDTH_DATA-1:0] wdata,
  output logic [WIDTH_DATA-1:0] rdata
);

  logic [WIDTH_DATA-1:0] ram [0:(1 << WIDTH_ADDR)-1];

  // Storage has no reset so that preloaded images survive a CPU reset.
  always_ff @(posedge clk) begin
    if (we) begin
      ram[addr] <= wdata;
    end
  end

  // The read register doubles as the bus read-data holding register, so it
  // only changes when a read completes and is cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= ram[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU memory bus.
// Accepts a request in IDLE, latches address/direction/write data, waits
// WAIT_STATES+1 cycles in WAIT, performs the array access on the edge into ACK
// and pulses mem_ready for one cycle. Writes below ROM_TOP are dropped and
// flagged with wr_fault. A test port preloads the array while IDLE.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   mem_req, mem_dir                  - request strobe, 0=write 1=read
//   mem_addr, mem_wdata               - access address and write data
//   mem_rdata                         - read data, held until the next read
//   mem_ready                         - one-cycle completion pulse
//   mem_busy                          - high whenever not IDLE
//   wr_fault                          - pulses with mem_ready on a dropped write
//   test_load_en/addr/data            - preload strobe, address, data
module mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH_MAIN  = MEM_WIDTH_MAIN,
  parameter int WIDTH_AX    = MEM_WIDTH_AX,
  parameter int WAIT_STATES = MEM_WAIT_STATES,
  parameter logic [WIDTH_AX-1:0] ROM_TOP = WIDTH_AX'(MEM_ROM_TOP)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic                  mem_dir,
  input  logic [WIDTH_AX-1:0]   mem_addr,
  input  logic [WIDTH_MAIN-1:0] mem_wdata,
  output logic [WIDTH_MAIN-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  wr_fault,
  input  logic                  test_load_en,
  input  logic [WIDTH_AX-1:0]   test_load_addr,
  input  logic [WIDTH_MAIN-1:0] test_load_data
);

  mem_state_t state, state_next;

  logic [MEM_WAIT_CNT_W-1:0] wait_cnt;
  logic [WIDTH_AX-1:0]       lat_addr;
  logic                      lat_dir;
  logic [WIDTH_MAIN-1:0]     lat_wdata;

  logic                  arr_we;
  logic                  arr_re;
  logic [WIDTH_AX-1:0]   arr_addr;
  logic [WIDTH_MAIN-1:0] arr_wdata;
  logic [WIDTH_MAIN-1:0] arr_rdata;

  logic rom_hit;
  logic wait_done;

  assign rom_hit   = (lat_addr < ROM_TOP);
  assign wait_done = (wait_cnt == '0);

  // State register, wait counter, request latches and the fault flag.
  // The fault flag is decided on the same edge that would have written the
  // array, so it lines up with the ACK cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MS_IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_dir   <= 1'b0;
      lat_wdata <= '0;
      wr_fault  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        MS_IDLE: begin
          if (!test_load_en && mem_req) begin
            lat_addr  <= mem_addr;
            lat_dir   <= mem_dir;
            lat_wdata <= mem_wdata;
            wait_cnt  <= MEM_WAIT_CNT_W'(WAIT_STATES);
          end
        end
        MS_WAIT: begin
          if (wait_done) begin
            wr_fault <= !lat_dir && rom_hit;
          end else begin
            wait_cnt <= wait_cnt - MEM_WAIT_CNT_W'(1);
          end
        end
        MS_ACK: begin
          wr_fault <= 1'b0;
        end
        default: begin
          wr_fault <= 1'b0;
        end
      endcase
    end
  end

  // Next state and array port steering. The array is touched only by a
  // test preload in IDLE or by the access on the WAIT->ACK edge; reset
  // suppresses both so an aborted transaction never writes.
  always_comb begin
    state_next = state;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    arr_addr   = lat_addr;
    arr_wdata  = lat_wdata;
    case (state)
      MS_IDLE: begin
        if (test_load_en) begin
          arr_we    = 1'b1;
          arr_addr  = test_load_addr;
          arr_wdata = test_load_data;
        end else if (mem_req) begin
          state_next = MS_WAIT;
        end
      end
      MS_WAIT: begin
        if (wait_done) begin
          state_next = MS_ACK;
          if (lat_dir) begin
            arr_re = 1'b1;
          end else if (!rom_hit) begin
            arr_we = 1'b1;
          end
        end
      end
      MS_ACK: begin
        state_next = MS_IDLE;
      end
      default: begin
        state_next = MS_IDLE;
      end
    endcase
    if (reset) begin
      arr_we = 1'b0;
      arr_re = 1'b0;
    end
  end

  assign mem_ready = (state == MS_ACK);
  assign mem_busy  = (state != MS_IDLE);
  assign mem_rdata = arr_rdata;

  mem_array #(
    .WIDTH_DATA(WIDTH_MAIN),
    .WIDTH_ADDR(WIDTH_AX)
  ) u_mem_array (
    .clk  (clk),
    .reset(reset),
    .we   (arr_we),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed, self-checking bench for mem_responder.
// Two instances share the bus inputs: dut uses WAIT_STATES=2 and is the main
// subject; dut_fast uses WAIT_STATES=0 and is observed only in the
// back-to-back phase. Expected results come from a small memory model and
// are queued when a request is driven, then popped when mem_ready is seen.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int WS = 2;

  typedef struct {
    string      tag;
    logic [7:0] rdata;
    logic       fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_dir;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        test_load_en;
  logic [15:0] test_load_addr;
  logic [7:0]  test_load_data;

  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        mem_busy;
  logic        wr_fault;

  logic [7:0]  f_rdata;
  logic        f_ready;
  logic        f_busy;
  logic        f_fault;

  int          n_compared = 0;
  int          n_mismatched = 0;
  exp_t        sb[$];
  logic [7:0]  model_mem [logic [15:0]];
  logic [7:0]  last_rd = 8'h00;

  always #5 clk = ~clk;

  mem_responder #(
    .WIDTH_MAIN(8), .WIDTH_AX(16), .WAIT_STATES(WS), .ROM_TOP(16'h8000)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_dir(mem_dir), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_busy(mem_busy), .wr_fault(wr_fault),
    .test_load_en(test_load_en), .test_load_addr(test_load_addr), .test_load_data(test_load_data)
  );

  mem_responder #(
    .WIDTH_MAIN(8), .WIDTH_AX(16), .WAIT_STATES(0), .ROM_TOP(16'h8000)
  ) dut_fast (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_dir(mem_dir), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(f_rdata), .mem_ready(f_ready), .mem_busy(f_busy), .wr_fault(f_fault),
    .test_load_en(test_load_en), .test_load_addr(test_load_addr), .test_load_data(test_load_data)
  );

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the responder is IDLE.
  task automatic preload(input logic [15:0] addr, input logic [7:0] data);
    test_load_en   = 1'b1;
    test_load_addr = addr;
    test_load_data = data;
    model_mem[addr] = data;
    @(negedge clk);
    test_load_en = 1'b0;
  endtask

  // Queues the expected outcome from the model and drives the request.
  task automatic apply_stimulus(input logic dir, input logic [15:0] addr,
                                input logic [7:0] wdata, input string tag);
    exp_t e;
    e.tag = tag;
    if (dir) begin
      last_rd = model_mem.exists(addr) ? model_mem[addr] : 8'h00;
    end else if (addr >= 16'h8000) begin
      model_mem[addr] = wdata;
    end
    e.rdata = last_rd;
    e.fault = !dir && (addr < 16'h8000);
    sb.push_back(e);
    mem_req   = 1'b1;
    mem_dir   = dir;
    mem_addr  = addr;
    mem_wdata = wdata;
  endtask

  task automatic check_output(input logic [7:0] obs_rdata, input logic obs_fault);
    exp_t e;
    if (sb.size() == 0) begin
      compare("scoreboard_nonempty", 32'(sb.size()), 32'(1));
    end else begin
      e = sb.pop_front();
      compare({e.tag, "_rdata"}, 32'(obs_rdata), 32'(e.rdata));
      compare({e.tag, "_fault"}, 32'(obs_fault), 32'(e.fault));
    end
  endtask

  // mode 1: move mem_addr to 0x9001 in the first WAIT cycle.
  // mode 2: pulse a test preload of 0x9005 during WAIT.
  task automatic wait_ready(input int mode, input string tag);
    int   cycles = 0;
    logic seen = 1'b0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (mode == 1 && cycles == 1) mem_addr = 16'h9001;
      if (mode == 2 && cycles == 1) begin
        test_load_en   = 1'b1;
        test_load_addr = 16'h9005;
        test_load_data = 8'h99;
      end
      if (mode == 2 && cycles == 2) test_load_en = 1'b0;
      if (mem_ready) seen = 1'b1;
    end
    compare({tag, "_latency"}, 32'(cycles), 32'(WS + 2));
    check_output(mem_rdata, wr_fault);
    mem_req = 1'b0;
    @(negedge clk);
    compare({tag, "_busy_after"}, 32'(mem_busy), 32'(0));
    compare({tag, "_fault_after"}, 32'(wr_fault), 32'(0));
    compare({tag, "_ready_after"}, 32'(mem_ready), 32'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    mem_req = 1'b0; mem_dir = 1'b0; mem_addr = '0; mem_wdata = '0;
    test_load_en = 1'b0; test_load_addr = '0; test_load_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    compare("reset_rdata", 32'(mem_rdata), 32'(0));
    compare("reset_ready", 32'(mem_ready), 32'(0));
    compare("reset_busy", 32'(mem_busy), 32'(0));
    compare("reset_fault", 32'(wr_fault), 32'(0));

    $display("[TB] preload and basic read");
    preload(16'h1234, 8'hA5);
    preload(16'h0010, 8'h5A);
    preload(16'h9001, 8'h11);
    preload(16'h9002, 8'h33);
    preload(16'h9004, 8'h22);
    preload(16'h9005, 8'h44);
    apply_stimulus(1'b1, 16'h1234, 8'h00, "rd_1234");
    @(posedge clk);
    #1 compare("busy_after_accept", 32'(mem_busy), 32'(1));
    wait_ready(0, "rd_1234");

    $display("[TB] write/read above and below the read-only boundary");
    apply_stimulus(1'b0, 16'h9000, 8'h3C, "wr_9000");
    wait_ready(0, "wr_9000");
    apply_stimulus(1'b1, 16'h9000, 8'h00, "rd_9000");
    wait_ready(0, "rd_9000");
    apply_stimulus(1'b0, 16'h0010, 8'h77, "wr_rom_0010");
    wait_ready(0, "wr_rom_0010");
    apply_stimulus(1'b1, 16'h0010, 8'h00, "rd_0010");
    wait_ready(0, "rd_0010");
    apply_stimulus(1'b0, 16'hFFFF, 8'hC3, "wr_ffff");
    wait_ready(0, "wr_ffff");
    apply_stimulus(1'b1, 16'hFFFF, 8'h00, "rd_ffff");
    wait_ready(0, "rd_ffff");

    $display("[TB] address change during WAIT");
    apply_stimulus(1'b1, 16'h9000, 8'h00, "rd_addr_hold");
    wait_ready(1, "rd_addr_hold");

    $display("[TB] preload colliding with a request");
    preload_collide: begin
      test_load_en   = 1'b1;
      test_load_addr = 16'h9003;
      test_load_data = 8'h66;
      model_mem[16'h9003] = 8'h66;
      apply_stimulus(1'b1, 16'h9003, 8'h00, "rd_collide");
      @(negedge clk);
      compare("collide_not_accepted", 32'(mem_busy), 32'(0));
      test_load_en = 1'b0;
      wait_ready(0, "rd_collide");
    end

    $display("[TB] preload during WAIT is ignored");
    apply_stimulus(1'b1, 16'h9004, 8'h00, "rd_9004");
    wait_ready(2, "rd_9004");
    apply_stimulus(1'b1, 16'h9005, 8'h00, "rd_9005");
    wait_ready(0, "rd_9005");

    $display("[TB] reset during WAIT of a write");
    mem_req = 1'b1; mem_dir = 1'b0; mem_addr = 16'h9002; mem_wdata = 8'hEE;
    @(negedge clk);
    compare("abort_busy_in_wait", 32'(mem_busy), 32'(1));
    reset = 1'b1;
    mem_req = 1'b0;
    @(negedge clk);
    compare("abort_rdata", 32'(mem_rdata), 32'(0));
    compare("abort_ready", 32'(mem_ready), 32'(0));
    compare("abort_busy", 32'(mem_busy), 32'(0));
    compare("abort_fault", 32'(wr_fault), 32'(0));
    reset = 1'b0;
    last_rd = 8'h00;
    apply_stimulus(1'b1, 16'h9002, 8'h00, "rd_after_abort");
    wait_ready(0, "rd_after_abort");

    $display("[TB] back-to-back reads with zero wait states");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e.tag = "b2b";
      e.rdata = 8'hA5;
      e.fault = 1'b0;
      sb.push_back(e);
    end
    mem_req = 1'b1; mem_dir = 1'b1; mem_addr = 16'h1234;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      compare($sformatf("b2b_ready_%0d", i), 32'(f_ready), 32'((i % 3) == 2));
      compare($sformatf("b2b_busy_%0d", i), 32'(f_busy), 32'((i % 3) != 0));
      if ((i % 3) == 2) check_output(f_rdata, f_fault);
    end
    mem_req = 1'b0;
    repeat (8) @(negedge clk);
    compare("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
